alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle controller that sequences the 8-bit ALU for the CPU core.
- Accepts one instruction at a time over a valid/ready handshake and holds a small register file plus a flags register.
- Drives the ALU operand and opcode inputs, captures Result and NZCV, writes back to the register file, then returns a response over a second valid/ready handshake.
- The ALU sits outside this block, connected through the alu_* ports.

Parameters:
DATA_W, 8, datapath width; must match ALU A/B/Result.
REG_AW, 2, register address width; register count is 2**REG_AW.
OP_W, 3, ALU opcode width; must match ALU OP_Code.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
instr_valid  input  1  instruction offered.
instr_ready  output  1  sequencer can accept an instruction.
instr_op  input  OP_W  ALU opcode.
instr_rd  input  REG_AW  destination register.
instr_ra  input  REG_AW  operand A register.
instr_imm_sel  input  1  1 = operand B is immediate; 0 = operand B is register rb.
instr_rb  input  REG_AW  operand B register.
instr_imm  input  DATA_W  operand B immediate.
alu_a  output  DATA_W  to ALU A.
alu_b  output  DATA_W  to ALU B.
alu_op  output  OP_W  to ALU OP_Code.
alu_result  input  DATA_W  from ALU Result (combinational ALU).
alu_nzcv  input  4  from ALU NZCV.
resp_valid  output  1  completed result available.
resp_ready  input  1  consumer accepts the response.
resp_data  output  DATA_W  value written to rd.
resp_nzcv  output  4  flags produced by the instruction.
flags  output  4  architectural NZCV register.
busy  output  1  high in every state except IDLE.
dbg_addr  input  REG_AW  debug read address.
dbg_data  output  DATA_W  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All registers, flags, alu_a, alu_b, alu_op, resp_data and resp_nzcv = 0.
  - resp_valid = 0, busy = 0.
  - instr_ready = 1 once rst_n is high.
- States: IDLE -> OPER -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch all instr_* fields and go to OPER.
  - Otherwise stay in IDLE.
- OPER:
  - Register alu_a = rf[ra].
  - Register alu_b = imm_sel ? imm : rf[rb].
  - Register alu_op = op.
  - Go to EXEC.
- EXEC:
  - ALU inputs are stable; sample alu_result and alu_nzcv into internal registers.
  - Go to WB.
- WB, on entry:
  - Write rf[rd] = sampled result.
  - flags = sampled nzcv.
  - resp_data and resp_nzcv = sampled values.
  - resp_valid = 1.
- WB, hold: resp_valid and its data stay asserted and stable until resp_ready.
  - Cycle with resp_valid & resp_ready: clear resp_valid and go to IDLE.
  - The register file is written exactly once per instruction, at WB entry; a stalled resp_ready never causes a rewrite.
- Latency: accept edge to resp_valid high is 3 cycles. Minimum issue interval is 4 cycles (resp_ready tied high).
- instr_ready = 0 in OPER, EXEC and WB. No pipelining, so there are no hazards.
- rd == ra or rd == rb: operands use pre-write values; the new value is visible to the next instruction.
- Results are DATA_W bits; the ALU handles carry/overflow and the sequencer only stores NZCV.
- alu_a, alu_b and alu_op hold their last values while in IDLE.
- Reset mid-instruction: the instruction is abandoned, no writeback occurs, and all state clears per the reset list above.
- dbg_data is purely combinational and reflects a WB write on the cycle after it.

Optional Feature:
- Macro: ALU_SEQ_COND_EXEC_EN.
- When defined:
  - Adds input instr_cond[1:0], latched with the instruction.
  - Adds output resp_skipped.
  - Condition: 00 = always; 01 = Z set; 10 = C set; 11 = N set.
  - The condition is evaluated against flags in OPER.
  - If false: still passes EXEC; in WB, no regfile or flags write; resp_data = old rf[rd]; resp_nzcv = current flags; resp_skipped = 1.
  - Latency is unchanged.
- When undefined: no extra ports, and every instruction executes.

Test Plan:
- Reset then idle: rst_n low 2 cycles then high -> instr_ready = 1, busy = 0, resp_valid = 0, flags = 0000, dbg_data = 0 for all four addresses.
- Immediate op, bench ALU stub returns A+B: rf all 0; issue rd=1, ra=0, imm_sel=1, imm=8'h05 -> alu_b = 8'h05 in EXEC; resp_valid 3 cycles after accept; resp_data = 8'h05; dbg_data[1] = 8'h05.
- Register op with dependency: r1 = 5; issue rd=2, ra=1, rb=1; stub returns 8'h0A and NZCV 0000 -> resp_data = 8'h0A. Then issue rd=2, ra=2, rb=2; stub returns 8'h80 and NZCV 1000 -> resp_data = 8'h80, flags = 1000.
- Response backpressure: resp_ready low 5 cycles after resp_valid -> resp_valid and resp_data stable, instr_ready = 0, r[rd] written once. resp_ready high -> next cycle IDLE and instr_ready = 1.
- Async reset mid-op: drop rst_n during EXEC of a write to r3 = 8'hFF -> outputs clear immediately and r3 stays 0 after release.
- With ALU_SEQ_COND_EXEC_EN, flags Z = 0: issue cond = 01, rd=0, imm=8'h33 -> resp_skipped = 1, r0 unchanged, flags unchanged. Repeat with cond = 00 -> r0 = 8'h33, resp_skipped = 0.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Instruction and response handshake bundle for alu_op_sequencer.
// ALU_SEQ_COND_EXEC_EN adds instr_cond and resp_skipped.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2,
  parameter int OP_W   = 3
);
  logic              instr_valid;
  logic              instr_ready;
  logic [OP_W-1:0]   instr_op;
  logic [REG_AW-1:0] instr_rd;
  logic [REG_AW-1:0] instr_ra;
  logic              instr_imm_sel;
  logic [REG_AW-1:0] instr_rb;
  logic [DATA_W-1:0] instr_imm;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [3:0]        resp_nzcv;
`ifdef ALU_SEQ_COND_EXEC_EN
  logic [1:0]        instr_cond;
  logic              resp_skipped;
`endif

  modport master (
    output instr_valid, instr_op, instr_rd, instr_ra, instr_imm_sel,
           instr_rb, instr_imm, resp_ready,
    input  instr_ready, resp_valid, resp_data, resp_nzcv
`ifdef ALU_SEQ_COND_EXEC_EN
    , output instr_cond
    , input  resp_skipped
`endif
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_ra, instr_imm_sel,
           instr_rb, instr_imm, resp_ready,
    output instr_ready, resp_valid, resp_data, resp_nzcv
`ifdef ALU_SEQ_COND_EXEC_EN
    , input  instr_cond
    , output resp_skipped
`endif
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for an external 8-bit ALU: regfile, NZCV flags, valid/ready in and out.
// Optional conditional execution is enabled by defining ALU_SEQ_COND_EXEC_EN.
//
// state | meaning
// IDLE  | ready for an instruction, ALU inputs hold their last values
// OPER  | read operands from the regfile into alu_a/alu_b/alu_op
// EXEC  | ALU inputs stable; result sampled, regfile/flags written on exit
// WB    | response held until resp_ready
module alu_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_nzcv,
  output logic [3:0]        flags,
  output logic              busy,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int NREG = 2**REG_AW;

  typedef enum logic [1:0] {S_IDLE, S_OPER, S_EXEC, S_WB} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [3:0]        flags_q, flags_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
  logic              isel_q, isel_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [3:0]        resp_nzcv_q, resp_nzcv_d;
  logic              exec_ok;
`ifdef ALU_SEQ_COND_EXEC_EN
  logic [1:0]        cond_q, cond_d;
  logic              cond_ok_q, cond_ok_d;
  logic              skipped_q, skipped_d;

  assign exec_ok          = cond_ok_q;
  assign bus.resp_skipped = skipped_q;
`else
  assign exec_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    rf_d         = rf_q;
    flags_d      = flags_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    op_d         = op_q;
    rd_d         = rd_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    isel_d       = isel_q;
    imm_d        = imm_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_nzcv_d  = resp_nzcv_q;
`ifdef ALU_SEQ_COND_EXEC_EN
    cond_d       = cond_q;
    cond_ok_d    = cond_ok_q;
    skipped_d    = skipped_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          op_d    = bus.instr_op;
          rd_d    = bus.instr_rd;
          ra_d    = bus.instr_ra;
          rb_d    = bus.instr_rb;
          isel_d  = bus.instr_imm_sel;
          imm_d   = bus.instr_imm;
`ifdef ALU_SEQ_COND_EXEC_EN
          cond_d  = bus.instr_cond;
`endif
          state_d = S_OPER;
        end
      end
      S_OPER: begin
        alu_a_d  = rf_q[ra_q];
        alu_b_d  = isel_q ? imm_q : rf_q[rb_q];
        alu_op_d = op_q;
`ifdef ALU_SEQ_COND_EXEC_EN
        // NZCV order is {N, Z, C, V}
        case (cond_q)
          2'b00:   cond_ok_d = 1'b1;
          2'b01:   cond_ok_d = flags_q[2];
          2'b10:   cond_ok_d = flags_q[1];
          default: cond_ok_d = flags_q[3];
        endcase
`endif
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // the only regfile write point, so a stalled response can never rewrite
        resp_valid_d = 1'b1;
        if (exec_ok) begin
          rf_d[rd_q]  = alu_result;
          flags_d     = alu_nzcv;
          resp_data_d = alu_result;
          resp_nzcv_d = alu_nzcv;
        end else begin
          resp_data_d = rf_q[rd_q];
          resp_nzcv_d = flags_q;
        end
`ifdef ALU_SEQ_COND_EXEC_EN
        skipped_d = ~exec_ok;
`endif
        state_d = S_WB;
      end
      S_WB: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      flags_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      op_q         <= '0;
      rd_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      isel_q       <= 1'b0;
      imm_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_nzcv_q  <= '0;
`ifdef ALU_SEQ_COND_EXEC_EN
      cond_q       <= '0;
      cond_ok_q    <= 1'b0;
      skipped_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rf_q         <= rf_d;
      flags_q      <= flags_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      isel_q       <= isel_d;
      imm_q        <= imm_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_nzcv_q  <= resp_nzcv_d;
`ifdef ALU_SEQ_COND_EXEC_EN
      cond_q       <= cond_d;
      cond_ok_q    <= cond_ok_d;
      skipped_q    <= skipped_d;
`endif
    end
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_nzcv   = resp_nzcv_q;
  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign alu_op          = alu_op_q;
  assign flags           = flags_q;
  assign busy            = (state_q != S_IDLE);
  assign dbg_data        = rf_q[dbg_addr];
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer against an architectural ISA model.
// Conditional-execution checks are compiled only with ALU_SEQ_COND_EXEC_EN.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic [3:0] alu_nzcv, flags;
  logic       busy;
  logic [1:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  logic       ovr_en = 1'b0;
  logic [7:0] ovr_res = '0;
  logic [3:0] ovr_nzcv = '0;

  logic [7:0] rf_m [4];
  logic [3:0] flags_m;
  int checks = 0;
  int errors = 0;

  alu_op_sequencer_if #(.DATA_W(8), .REG_AW(2), .OP_W(3)) bus ();

  alu_op_sequencer #(.DATA_W(8), .REG_AW(2), .OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_nzcv(alu_nzcv),
    .flags(flags), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // returns {N, Z, C, V, result}
  function automatic logic [11:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic v;
    w = '0;
    v = 1'b0;
    case (op)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (w[7] != a[7]); end
      3'd1: begin w = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (w[7] != a[7]); end
      3'd2: w = {1'b0, a & b};
      3'd3: w = {1'b0, a | b};
      3'd4: w = {1'b0, a ^ b};
      3'd5: w = {1'b0, a};
      3'd6: w = {1'b0, b};
      default: w = {1'b0, ~a};
    endcase
    return {w[7], (w[7:0] == 8'h00), w[8], v, w[7:0]};
  endfunction

  function automatic logic cond_true(input logic [1:0] c, input logic [3:0] f);
    case (c)
      2'b00:   return 1'b1;
      2'b01:   return f[2];
      2'b10:   return f[1];
      default: return f[3];
    endcase
  endfunction

  always_comb begin
    logic [11:0] t;
    t = alu_fn(alu_op, alu_a, alu_b);
    alu_result = ovr_en ? ovr_res  : t[7:0];
    alu_nzcv   = ovr_en ? ovr_nzcv : t[11:8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic isel, input logic [1:0] rb, input logic [7:0] imm,
                       input logic [1:0] cond, input int stall);
    logic [7:0]  a_m, b_m, exp_data;
    logic [3:0]  exp_nzcv;
    logic [11:0] r;
    logic        ex, sv_en;
    logic [7:0]  sv_res;
    logic [3:0]  sv_nzcv;
    int lat;
    a_m = rf_m[ra];
    b_m = isel ? imm : rf_m[rb];
    r   = ovr_en ? {ovr_nzcv, ovr_res} : alu_fn(op, a_m, b_m);
`ifdef ALU_SEQ_COND_EXEC_EN
    ex = cond_true(cond, flags_m);
`else
    ex = 1'b1;
`endif
    chk("instr_ready_idle", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr_valid   = 1'b1;
    bus.instr_op      = op;
    bus.instr_rd      = rd;
    bus.instr_ra      = ra;
    bus.instr_imm_sel = isel;
    bus.instr_rb      = rb;
    bus.instr_imm     = imm;
`ifdef ALU_SEQ_COND_EXEC_EN
    bus.instr_cond    = cond;
`endif
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr_op    = 3'($urandom);
    bus.instr_rd    = 2'($urandom);
    bus.instr_imm   = 8'($urandom);
    while (lat < 20) begin
      if (bus.resp_valid) break;
      if (lat == 2) begin
        chk("alu_a_exec", {24'd0, alu_a}, {24'd0, a_m});
        chk("alu_b_exec", {24'd0, alu_b}, {24'd0, b_m});
        chk("alu_op_exec", {29'd0, alu_op}, {29'd0, op});
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, 3);
    if (ex) begin
      rf_m[rd] = r[7:0];
      flags_m  = r[11:8];
      exp_data = r[7:0];
      exp_nzcv = r[11:8];
    end else begin
      exp_data = rf_m[rd];
      exp_nzcv = flags_m;
    end
    chk("resp_data", {24'd0, bus.resp_data}, {24'd0, exp_data});
    chk("resp_nzcv", {28'd0, bus.resp_nzcv}, {28'd0, exp_nzcv});
    chk("flags_wb", {28'd0, flags}, {28'd0, flags_m});
    chk("instr_ready_wb", {31'd0, bus.instr_ready}, 32'd0);
    chk("busy_wb", {31'd0, busy}, 32'd1);
`ifdef ALU_SEQ_COND_EXEC_EN
    chk("resp_skipped", {31'd0, bus.resp_skipped}, {31'd0, ~ex});
`endif
    sv_en = ovr_en; sv_res = ovr_res; sv_nzcv = ovr_nzcv;
    ovr_en = 1'b1; ovr_res = ~exp_data; ovr_nzcv = ~exp_nzcv;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("stall_data", {24'd0, bus.resp_data}, {24'd0, exp_data});
      chk("stall_ready", {31'd0, bus.instr_ready}, 32'd0);
      dbg_addr = rd;
      #1 chk("stall_rf_once", {24'd0, dbg_data}, {24'd0, rf_m[rd]});
    end
    ovr_en = sv_en; ovr_res = sv_res; ovr_nzcv = sv_nzcv;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("resp_valid_clr", {31'd0, bus.resp_valid}, 32'd0);
    chk("instr_ready_back", {31'd0, bus.instr_ready}, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    dbg_addr = 2'($urandom);
    #1 chk("dbg_data", {24'd0, dbg_data}, {24'd0, rf_m[dbg_addr]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) rf_m[i] = '0;
    flags_m = '0;
    bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_rd = '0; bus.instr_ra = '0;
    bus.instr_imm_sel = 1'b0; bus.instr_rb = '0; bus.instr_imm = '0; bus.resp_ready = 1'b0;
`ifdef ALU_SEQ_COND_EXEC_EN
    bus.instr_cond = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_instr_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1 chk("rst_dbg", {24'd0, dbg_data}, 32'd0);
    end

    issue(3'd0, 2'd1, 2'd0, 1'b1, 2'd0, 8'h05, 2'b00, 0);
    dbg_addr = 2'd1;
    #1 chk("imm_r1", {24'd0, dbg_data}, 32'h05);

    issue(3'd0, 2'd2, 2'd1, 1'b0, 2'd1, 8'h00, 2'b00, 0);
    ovr_en = 1'b1; ovr_res = 8'h80; ovr_nzcv = 4'b1000;
    issue(3'd0, 2'd2, 2'd2, 1'b0, 2'd2, 8'h00, 2'b00, 0);
    ovr_en = 1'b0;
    chk("dep_flags", {28'd0, flags}, 32'h8);
    dbg_addr = 2'd2;
    #1 chk("dep_r2", {24'd0, dbg_data}, 32'h80);

`ifdef ALU_SEQ_COND_EXEC_EN
    issue(3'd0, 2'd0, 2'd0, 1'b1, 2'd0, 8'h33, 2'b01, 0);
    dbg_addr = 2'd0;
    #1 chk("cond_skip_r0", {24'd0, dbg_data}, 32'h00);
    chk("cond_skip_flags", {28'd0, flags}, 32'h8);
    issue(3'd0, 2'd0, 2'd0, 1'b1, 2'd0, 8'h33, 2'b00, 0);
    dbg_addr = 2'd0;
    #1 chk("cond_exec_r0", {24'd0, dbg_data}, 32'h33);
`endif

    issue(3'd0, 2'd3, 2'd1, 1'b1, 2'd0, 8'h11, 2'b00, 5);

    for (int n = 0; n < 40; n++) begin
      issue(3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
            8'($urandom), 2'($urandom), int'($urandom_range(0, 2)));
    end

    // abandon an instruction mid-flight: r3 must be cleared and stay cleared
    ovr_en = 1'b1; ovr_res = 8'hFF; ovr_nzcv = 4'b1000;
    bus.instr_valid = 1'b1; bus.instr_op = 3'd0; bus.instr_rd = 2'd3; bus.instr_ra = 2'd0;
    bus.instr_imm_sel = 1'b1; bus.instr_imm = 8'hFF;
`ifdef ALU_SEQ_COND_EXEC_EN
    bus.instr_cond = 2'b00;
`endif
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy_exec", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) rf_m[i] = '0;
    flags_m = '0;
    chk("mid_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_alu_a", {24'd0, alu_a}, 32'd0);
    chk("mid_alu_b", {24'd0, alu_b}, 32'd0);
    chk("mid_flags", {28'd0, flags}, 32'd0);
    chk("mid_resp_data", {24'd0, bus.resp_data}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ovr_en = 1'b0;
    repeat (3) @(negedge clk);
    dbg_addr = 2'd3;
    #1 chk("mid_r3_zero", {24'd0, dbg_data}, 32'd0);
    chk("mid_ready_after", {31'd0, bus.instr_ready}, 32'd1);
    chk("mid_flags_after", {28'd0, flags}, {28'd0, flags_m});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
